// File: rtl/mux_rr_nto1_if.sv
// mux_rr_nto1_if: handshake bundle for the N-to-1 registered mux (out_par present when MUX_PARITY_EN is defined)
interface mux_rr_nto1_if #(
  parameter int N = 4,
  parameter int W = 8,
  parameter int SW = $clog2(N)
);
  logic            enable;
  logic            mode;
  logic [SW-1:0]   s;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_ch;
  logic            out_valid;
  logic            out_ready;
`ifdef MUX_PARITY_EN
  logic            out_par;
  modport master (
    output enable, mode, s, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid, out_par
  );
  modport slave (
    input  enable, mode, s, in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid, out_par
  );
`else
  modport master (
    output enable, mode, s, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );
  modport slave (
    input  enable, mode, s, in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );
`endif
endinterface

// File: rtl/mux_rr_nto1.sv
// mux_rr_nto1: registered N:1 valid/ready mux with direct or round-robin select; MUX_PARITY_EN adds out_par
module mux_rr_nto1 #(
  parameter int N = 4,
  parameter int W = 8,
  parameter int SW = $clog2(N)
) (
  input logic clk,
  input logic rst,
  mux_rr_nto1_if.slave bus
);
  logic [SW-1:0] ptr;
  logic          load;
  logic [SW:0]   s_ext;
  logic          dir_hit;
  logic          rr_hit;
  logic [SW-1:0] rr_g;
  logic          grant;
  logic [SW-1:0] g;
  logic [W-1:0]  sel_data;
  int            d;
  int            best;
  // Round-robin search: the valid channel closest after ptr (ptr itself comes last) wins
  always_comb begin
    rr_hit = 1'b0;
    rr_g = '0;
    best = N;
    d = 0;
    for (int i = 0; i < N; i++) begin
      d = (i - int'(ptr) - 1 + N) % N;
      if (bus.in_valid[i] && d < best) begin
        best = d;
        rr_g = SW'(i);
        rr_hit = 1'b1;
      end
    end
  end
  // Grant decision; reset blocks any acceptance, out-of-range select never grants
  always_comb begin
    load = !bus.out_valid || bus.out_ready;
    s_ext = {1'b0, bus.s};
    dir_hit = (s_ext < (SW+1)'(N)) && bus.in_valid[bus.s];
    grant = !rst && bus.enable && load && (bus.mode ? rr_hit : dir_hit);
    g = bus.mode ? rr_g : bus.s;
    bus.in_ready = grant ? (N'(1) << g) : '0;
  end
  // Steer the granted channel's word to the output register input
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++)
      if (g == SW'(i)) sel_data = bus.in_data[i*W +: W];
  end
  // Output register and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_ch <= '0;
      ptr <= SW'(N-1);
    end else if (load) begin
      bus.out_valid <= grant;
      if (grant) begin
        bus.out_data <= sel_data;
        bus.out_ch <= g;
        if (bus.mode) ptr <= g;
      end
    end
  end
`ifdef MUX_PARITY_EN
  // Parity of the transferred word, loaded alongside out_data
  always_ff @(posedge clk) begin
    if (rst) bus.out_par <= 1'b0;
    else if (grant) bus.out_par <= ^sel_data;
  end
`endif
endmodule

// File: tb/tb_mux_rr_nto1.sv
// tb_mux_rr_nto1: table vectors, hand sequences and randomized model check for mux_rr_nto1
module tb_mux_rr_nto1;
  localparam int N = 4;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  mux_rr_nto1_if #(.N(N), .W(W)) bus ();
  mux_rr_nto1 #(.N(N), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic       mode;
    logic [1:0] s;
    logic [3:0] vld;
    logic       rdy;
    logic [3:0] x_irdy;
    logic       x_v;
    logic [7:0] x_d;
    logic [1:0] x_ch;
  } vec_t;
  vec_t tbl [26];

  logic       m_v;
  logic [7:0] m_d;
  logic [1:0] m_ch;
  logic       m_p;
  int         m_last;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Spec-level grant rule evaluated from the current inputs and the model's output state
  function automatic void pick(output logic hit, output int gch);
    logic [3:0] vv;
    int c;
    vv = bus.in_valid;
    hit = 1'b0;
    gch = 0;
    if (!rst && bus.enable && (!m_v || bus.out_ready)) begin
      if (!bus.mode) begin
        c = int'(bus.s);
        if (c < N && vv[c[1:0]]) begin hit = 1'b1; gch = c; end
      end else begin
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (!hit && vv[c[1:0]]) begin hit = 1'b1; gch = c; end
        end
      end
    end
  endfunction

  // One cycle against the model: check in_ready before the edge, outputs after it
  task automatic model_cycle(input string tag);
    logic hit;
    int gch;
    logic [7:0] w;
    logic [3:0] exp_ir;
    logic ld;
    #1;
    pick(hit, gch);
    exp_ir = hit ? 4'(1 << gch) : 4'd0;
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'(exp_ir));
    w = bus.in_data[gch*W +: W];
    ld = !m_v || bus.out_ready;
    @(posedge clk);
    if (rst) begin
      m_v = 1'b0; m_d = 8'h00; m_ch = 2'd0; m_p = 1'b0; m_last = N-1;
    end else if (ld) begin
      m_v = hit;
      if (hit) begin
        m_d = w; m_ch = 2'(gch); m_p = ^w;
        if (bus.mode) m_last = gch;
      end
    end
    #1;
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'(m_v));
    check({tag, "_out_data"}, 64'(bus.out_data), 64'(m_d));
    check({tag, "_out_ch"}, 64'(bus.out_ch), 64'(m_ch));
`ifdef MUX_PARITY_EN
    check({tag, "_out_par"}, 64'(bus.out_par), 64'(m_p));
`endif
  endtask

  task automatic drive(input logic r, input logic en, input logic md, input logic [1:0] sel,
                       input logic [3:0] vld, input logic rdy);
    rst = r; bus.enable = en; bus.mode = md; bus.s = sel; bus.in_valid = vld; bus.out_ready = rdy;
  endtask

  initial begin
    //            rst en md s  vld    rdy irdy   v  data   ch
    tbl[0]  = '{1'b1,1'b1,1'b1,2'd0,4'hF,1'b1,4'h0,1'b0,8'h00,2'd0};
    tbl[1]  = '{1'b1,1'b1,1'b1,2'd0,4'hF,1'b1,4'h0,1'b0,8'h00,2'd0};
    tbl[2]  = '{1'b0,1'b1,1'b1,2'd0,4'hF,1'b1,4'h1,1'b1,8'h11,2'd0};
    tbl[3]  = '{1'b0,1'b1,1'b0,2'd0,4'hF,1'b1,4'h1,1'b1,8'h11,2'd0};
    tbl[4]  = '{1'b0,1'b1,1'b0,2'd1,4'hF,1'b1,4'h2,1'b1,8'h22,2'd1};
    tbl[5]  = '{1'b0,1'b1,1'b0,2'd2,4'hF,1'b1,4'h4,1'b1,8'h33,2'd2};
    tbl[6]  = '{1'b0,1'b1,1'b0,2'd3,4'hF,1'b1,4'h8,1'b1,8'h44,2'd3};
    tbl[7]  = '{1'b0,1'b1,1'b1,2'd0,4'hF,1'b1,4'h2,1'b1,8'h22,2'd1};
    tbl[8]  = '{1'b0,1'b1,1'b1,2'd0,4'hA,1'b1,4'h8,1'b1,8'h44,2'd3};
    tbl[9]  = '{1'b0,1'b1,1'b1,2'd0,4'hA,1'b1,4'h2,1'b1,8'h22,2'd1};
    tbl[10] = '{1'b0,1'b1,1'b1,2'd0,4'hA,1'b1,4'h8,1'b1,8'h44,2'd3};
    tbl[11] = '{1'b0,1'b1,1'b1,2'd0,4'hA,1'b1,4'h2,1'b1,8'h22,2'd1};
    tbl[12] = '{1'b0,1'b1,1'b1,2'd0,4'hA,1'b0,4'h0,1'b1,8'h22,2'd1};
    tbl[13] = '{1'b0,1'b1,1'b1,2'd0,4'hA,1'b0,4'h0,1'b1,8'h22,2'd1};
    tbl[14] = '{1'b0,1'b1,1'b1,2'd0,4'hA,1'b0,4'h0,1'b1,8'h22,2'd1};
    tbl[15] = '{1'b0,1'b1,1'b1,2'd0,4'hA,1'b1,4'h8,1'b1,8'h44,2'd3};
    tbl[16] = '{1'b0,1'b0,1'b1,2'd0,4'hF,1'b1,4'h0,1'b0,8'h44,2'd3};
    tbl[17] = '{1'b0,1'b0,1'b0,2'd1,4'hF,1'b1,4'h0,1'b0,8'h44,2'd3};
    tbl[18] = '{1'b0,1'b1,1'b0,2'd2,4'hB,1'b1,4'h0,1'b0,8'h44,2'd3};
    tbl[19] = '{1'b0,1'b1,1'b0,2'd0,4'hB,1'b1,4'h1,1'b1,8'h11,2'd0};
    tbl[20] = '{1'b0,1'b1,1'b0,2'd2,4'hB,1'b0,4'h0,1'b1,8'h11,2'd0};
    tbl[21] = '{1'b0,1'b1,1'b0,2'd2,4'hB,1'b1,4'h0,1'b0,8'h11,2'd0};
    tbl[22] = '{1'b0,1'b1,1'b0,2'd1,4'hF,1'b1,4'h2,1'b1,8'h22,2'd1};
    tbl[23] = '{1'b1,1'b1,1'b0,2'd1,4'hF,1'b0,4'h0,1'b0,8'h00,2'd0};
    tbl[24] = '{1'b0,1'b1,1'b1,2'd0,4'hF,1'b1,4'h1,1'b1,8'h11,2'd0};
    tbl[25] = '{1'b0,1'b1,1'b1,2'd0,4'hF,1'b1,4'h2,1'b1,8'h22,2'd1};
    bus.in_data = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].mode, tbl[i].s, tbl[i].vld, tbl[i].rdy);
      #1;
      check($sformatf("vec%0d_in_ready", i), 64'(bus.in_ready), 64'(tbl[i].x_irdy));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_out_valid", i), 64'(bus.out_valid), 64'(tbl[i].x_v));
      check($sformatf("vec%0d_out_data", i), 64'(bus.out_data), 64'(tbl[i].x_d));
      check($sformatf("vec%0d_out_ch", i), 64'(bus.out_ch), 64'(tbl[i].x_ch));
    end
    // Fairness: all channels valid after reset gives 0,1,2,3,0,1,2,3
    drive(1'b1, 1'b1, 1'b1, 2'd0, 4'hF, 1'b1);
    model_cycle("fair_rst");
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 1'b1, 2'd0, 4'hF, 1'b1);
      model_cycle("fair");
      check("fair_order", 64'(bus.out_ch), 64'(i % N));
    end
`ifdef MUX_PARITY_EN
    bus.in_data = {8'h44, 8'h33, 8'h22, 8'h07};
    drive(1'b0, 1'b1, 1'b0, 2'd0, 4'hF, 1'b1);
    model_cycle("par07");
    check("par07_is_one", 64'(bus.out_par), 64'd1);
`endif
    // Randomized traffic against the model, starting from a reset
    drive(1'b1, 1'b1, 1'b1, 2'd0, 4'h0, 1'b1);
    model_cycle("rnd_rst");
    for (int t = 0; t < 600; t++) begin
      bus.in_data = $urandom;
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
      model_cycle("rnd");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux_rr_nto1.md
# mux_rr_nto1

Registered N-channel, W-bit multiplexer with valid/ready handshakes on every input and on the output. It selects one channel per cycle, either directly by a select input or by round-robin arbitration among requesting channels. It sits between parallel producer channels and a single downstream consumer. It extends the combinational 4:1 enable mux with width and channel generalisation, flow control, and fair scheduling.

## Interface
- N, 4: number of input channels, 2..16.
- W, 8: data width per channel, 1..64.
- SW, $clog2(N): derived select width; do not override.

- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  grant enable; when low, no new channel is accepted.
- mode  in  1  0 = direct select by s; 1 = round-robin.
- s  in  SW  channel select, used in direct mode only.
- in_data  in  N*W  channel i occupies bits [i*W +: W].
- in_valid  in  N  per-channel valid.
- in_ready  out  N  per-channel ready; at most one bit high per cycle.
- out_data  out  W  registered selected data.
- out_ch  out  SW  index of the channel that produced out_data.
- out_valid  out  1  output register holds data.
- out_ready  in  1  downstream accepts when out_valid && out_ready.

## Operation
- Single output register stage. Load condition: `load = !out_valid || out_ready`.
- Grant (combinational):
  - Direct mode: grant channel s if enable && load && in_valid[s] && s < N. Otherwise no grant. An out-of-range s (N not a power of two) never grants.
  - Round-robin mode: search channels ptr+1, ptr+2, … mod N. Grant the first with in_valid high, if enable && load.
- in_ready[g] = 1 only for the granted channel g. All other bits are 0. in_ready never depends on in_valid of other channels in direct mode.
- Transfer on channel g: out_data <= in_data[g], out_ch <= g, out_valid <= 1.
- In round-robin mode only, ptr <= g on a transfer. Direct-mode transfers do not move ptr.
- If load && no grant: out_valid <= 0. out_data and out_ch hold their last values.
- If !load: the output register holds.
- enable low:
  - No grants.
  - A pending output still drains via out_ready; out_valid then falls.
  - out_data holds its value and never goes X.
- A mode change takes effect on the same cycle's grant. ptr is retained across mode changes.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_ch = 0, in_ready = 0 during the reset cycle, ptr = N-1. The first round-robin search therefore starts at channel 0.
- rst asserted mid-transfer: the output register is dropped (out_valid = 0 the next cycle). in_ready is forced to 0 while rst is high, so no input is accepted.
- Latency: input transfer at edge k → out_valid/out_data visible after edge k.
- Throughput: one word per cycle with out_ready held high. Back-to-back grants are allowed, including to the same channel in direct mode.
- Backpressure: out_valid && !out_ready → all in_ready = 0. out_data, out_ch and out_valid are stable until accepted.
- Simultaneous drain and load, out_valid && out_ready && grant: the register reloads in the same cycle with no bubble.
- Round-robin fairness: with all channels continuously valid, grants cycle 0,1,…,N-1,0. Any valid channel is served within N transfers.
- ptr wrap: ptr = N-1 searches from 0.

## Configuration
- MUX_PARITY_EN defined:
  - Adds output port out_par (1 bit).
  - out_par is registered with out_data and equals ^in_data[g] of the transferred word.
  - Reset value 0. out_par holds whenever out_data holds.
- MUX_PARITY_EN undefined: no out_par port and no parity logic. All other behaviour is identical.

## Test plan
- Reset: hold rst 2 cycles with all in_valid = 1 → out_valid = 0, out_data = 0, out_ch = 0, in_ready = 0. After release in round-robin mode, the first grant is channel 0.
- Direct select (N=4, W=8): enable = 1, mode = 0, out_ready = 1, in_data = {8'h44, 8'h33, 8'h22, 8'h11}, all valid; sweep s = 0..3 → one cycle later out_data = 11, 22, 33, 44 and out_ch = 0..3. ptr does not move.
- Round-robin: mode = 1, in_valid = 4'b1010, out_ready = 1 → grants alternate 1, 3, 1, 3. in_ready is one-hot on the granted channel.
- Backpressure: out_ready = 0 for 3 cycles after a transfer → out_data and out_ch stable, out_valid = 1, all in_ready = 0. Raising out_ready gives a reload in the same cycle with no idle cycle.
- Enable/disable: drop enable while out_valid = 1 and out_ready = 1 → out_valid = 0 the next cycle, out_data holds. No in_ready is asserted until enable returns.
- Invalid and edge cases:
  - Direct mode with in_valid[s] = 0 → no grant; out_valid drops after drain.
  - With MUX_PARITY_EN, in_data[g] = 8'h07 → out_par = 1.
